mem_port_arbiter: RTL and testbench

- Shares one single-port backing memory between instruction fetch (read-only) and the memory_access stage (read/write).
- Sits between the pipeline stages and the memory macro.
- Serialises requests with one transaction in flight, and handles latency counting and response capture.
- The data port has priority, bounded by a streak limit so that fetch cannot starve.

---
 rtl/mem_port_arbiter_pkg.sv | 5 +
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic [1:0] {OWNER_NONE, OWNER_IF, OWNER_MA} arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port (if_*), data port (ma_*) and memory macro port (mem_*); slave = arbiter, master = pipeline/memory side
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        ma_req;
  logic        ma_we;
  logic [3:0]  ma_be;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic        ma_ready;
  logic [31:0] ma_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, ma_req, ma_we, ma_be, ma_addr, ma_wdata, mem_rdata,
    output if_ready, if_rdata, ma_ready, ma_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ma_req, ma_we, ma_be, ma_addr, ma_wdata, mem_rdata,
    input  if_ready, if_rdata, ma_ready, ma_rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data requests onto one memory port (clk, rst_n, bus: slave side of mem_port_arbiter_if)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY   = 1,
  parameter int MAX_MA_STREAK = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_MA_STREAK);
  localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);
  arb_state_t  r_state;
  arb_owner_t  r_owner;
  logic [3:0]  r_streak;
  logic [3:0]  r_cnt;
  logic        r_if_ready;
  logic [31:0] r_if_rdata;
  logic        r_ma_ready;
  logic [31:0] r_ma_rdata;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  arb_owner_t  w_grant;
  logic        w_is_ma;
  function automatic arb_owner_t grant(input logic i_if, input logic i_ma, input logic [3:0] i_streak);
    return (i_ma && !(i_if && i_streak == STREAK_MAX)) ? OWNER_MA : i_if ? OWNER_IF : OWNER_NONE;
  endfunction
  assign w_grant = grant(bus.if_req, bus.ma_req, r_streak);
  assign w_is_ma = w_grant == OWNER_MA;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWNER_NONE;
      r_streak    <= '0;
      r_cnt       <= '0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_ma_ready  <= 1'b0;
      r_ma_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en   <= 1'b0;
      r_if_ready <= 1'b0;
      r_ma_ready <= 1'b0;
      case (r_state)
        ARB_IDLE: if (w_grant != OWNER_NONE) begin
          r_owner     <= w_grant;
          r_state     <= ARB_ISSUE;
          r_mem_en    <= 1'b1;
          r_mem_we    <= w_is_ma && bus.ma_we;
          r_mem_be    <= w_is_ma ? bus.ma_be : 4'hF;
          r_mem_addr  <= w_is_ma ? bus.ma_addr : bus.if_addr;
          r_mem_wdata <= w_is_ma ? bus.ma_wdata : r_mem_wdata;
          r_streak    <= (w_is_ma && bus.if_req) ? r_streak + 4'd1 : 4'd0;
        end
        ARB_ISSUE: begin
          r_state    <= r_mem_we ? ARB_RESP : ARB_WAIT;
          r_cnt      <= LAT_M1;
          r_ma_ready <= r_mem_we;
        end
        ARB_WAIT: if (r_cnt == 4'd0) begin
          r_if_rdata <= r_owner == OWNER_IF ? bus.mem_rdata : r_if_rdata;
          r_ma_rdata <= r_owner == OWNER_MA ? bus.mem_rdata : r_ma_rdata;
          r_if_ready <= r_owner == OWNER_IF;
          r_ma_ready <= r_owner == OWNER_MA;
          r_state    <= ARB_RESP;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        default: begin
          r_state <= ARB_IDLE;
          r_owner <= OWNER_NONE;
        end
      endcase
    end
  end
  assign bus.if_ready  = r_if_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ma_ready  = r_ma_ready;
  assign bus.ma_rdata  = r_ma_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven bench with a latency-accurate memory model
module tb_mem_port_arbiter;
  localparam int L = 3;
  localparam int S = 4;
  typedef struct {
    logic        is_if;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_if = '0;
  logic [31:0] m_ma = '0;
  logic [31:0] mem [256];
  logic [31:0] pipe [L];
  vec_t v [8];
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.MEM_LATENCY(L), .MAX_MA_STREAK(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h40] <= 32'h0050_0093;
      mem[8'h80] <= 32'h1111_2222;
      mem[8'h10] <= 32'hCAFE_BABE;
      mem[8'h11] <= 32'h1234_5678;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[9:2]] : 32'hDEAD_DEAD;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[L-1];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {24'h0, bus.if_ready, bus.ma_ready, bus.mem_en, bus.mem_we, bus.mem_be}, 32'h0);
    chk({tag, "_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
    chk({tag, "_ma_rdata"}, bus.ma_rdata, 32'h0);
  endtask
  task automatic run_vec(input string tag, input vec_t t);
    int rdy_n, en_n, en_cnt, stray;
    logic [31:0] f_addr, f_wdata;
    logic [3:0] f_be;
    logic f_we;
    rdy_n = 0; en_n = 0; en_cnt = 0; stray = 0;
    f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0;
    @(posedge clk); #1;
    if (t.is_if) begin
      bus.if_addr = t.addr; bus.if_req = 1'b1;
    end else begin
      bus.ma_addr = t.addr; bus.ma_we = t.we; bus.ma_be = t.be; bus.ma_wdata = t.wdata; bus.ma_req = 1'b1;
    end
    for (int n = 1; n <= 40 && rdy_n == 0; n++) begin
      @(posedge clk); #1;
      if (bus.mem_en) begin
        en_cnt++;
        if (en_n == 0) begin
          en_n = n; f_addr = bus.mem_addr; f_wdata = bus.mem_wdata; f_be = bus.mem_be; f_we = bus.mem_we;
        end
      end
      if (t.is_if ? bus.ma_ready : bus.if_ready) stray++;
      if (t.is_if ? bus.if_ready : bus.ma_ready) begin
        rdy_n = n; bus.if_req = 1'b0; bus.ma_req = 1'b0;
      end
    end
    bus.if_req = 1'b0; bus.ma_req = 1'b0;
    chk({tag, "_en_cycle"}, en_n, 1);
    chk({tag, "_en_count"}, en_cnt, 1);
    chk({tag, "_addr"}, f_addr, t.addr);
    chk({tag, "_we"}, {31'h0, f_we}, {31'h0, !t.is_if && t.we});
    chk({tag, "_be"}, {28'h0, f_be}, {28'h0, t.is_if ? 4'hF : t.be});
    chk({tag, "_stray_ready"}, stray, 0);
    if (!t.is_if && t.we) begin
      chk({tag, "_wdata"}, f_wdata, t.wdata);
      chk({tag, "_latency"}, rdy_n, 2);
      chk({tag, "_memword"}, mem[t.addr[9:2]], t.exp);
    end else begin
      chk({tag, "_latency"}, rdy_n, L + 2);
      chk({tag, "_rdata"}, t.is_if ? bus.if_rdata : bus.ma_rdata, t.exp);
      if (t.is_if) m_if = t.exp; else m_ma = t.exp;
    end
    chk({tag, "_if_hold"}, bus.if_rdata, m_if);
    chk({tag, "_ma_hold"}, bus.ma_rdata, m_ma);
  endtask
  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.ma_req = 0; bus.ma_we = 0; bus.ma_be = 0; bus.ma_addr = 0; bus.ma_wdata = 0;
    v[0] = '{1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0050_0093};
    v[1] = '{1'b0, 1'b1, 4'b1100, 32'h202, 32'hBEEF_0000, 32'hBEEF_2222};
    v[2] = '{1'b0, 1'b0, 4'hF, 32'h200, 32'h0, 32'hBEEF_2222};
    v[3] = '{1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_BABE};
    v[4] = '{1'b0, 1'b1, 4'h0, 32'h40, 32'hFFFF_FFFF, 32'hCAFE_BABE};
    v[5] = '{1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 32'hCAFE_BABE};
    v[6] = '{1'b0, 1'b1, 4'b0001, 32'h44, 32'h0000_00AB, 32'h1234_56AB};
    v[7] = '{1'b1, 1'b0, 4'hF, 32'h44, 32'h0, 32'h1234_56AB};
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), v[i]);
    begin
      logic got [10];
      logic exp_ma [10];
      int k, last, min_gap;
      exp_ma = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      got = '{default: 1'b0};
      k = 0; last = 0; min_gap = 1000;
      @(posedge clk); #1;
      bus.if_addr = 32'h100; bus.ma_addr = 32'h40; bus.ma_we = 0; bus.ma_be = 4'hF;
      bus.if_req = 1; bus.ma_req = 1;
      for (int n = 1; n <= 300 && k < 10; n++) begin
        @(posedge clk); #1;
        if (bus.mem_en) begin
          got[k] = bus.mem_addr == 32'h40;
          if (k > 0 && n - last < min_gap) min_gap = n - last;
          last = n;
          k++;
        end
      end
      bus.if_req = 0; bus.ma_req = 0;
      chk("streak_count", k, 10);
      for (int i = 0; i < 10; i++) chk($sformatf("streak_grant%0d", i), {31'h0, got[i]}, {31'h0, exp_ma[i]});
      chk("streak_min_gap", min_gap, L + 3);
      repeat (20) @(posedge clk);
      #1;
      m_if = 32'h0050_0093; m_ma = 32'hCAFE_BABE;
      chk("streak_if_rdata", bus.if_rdata, m_if);
      chk("streak_ma_rdata", bus.ma_rdata, m_ma);
    end
    begin
      int if_rdy_n, if_rdy_cnt, ma_en_n, ma_rdy_n, if_en_n;
      if_rdy_n = 0; if_rdy_cnt = 0; ma_en_n = 0; ma_rdy_n = 0; if_en_n = 0;
      @(posedge clk); #1;
      bus.if_addr = 32'h100; bus.if_req = 1;
      for (int n = 1; n <= 60 && ma_rdy_n == 0; n++) begin
        @(posedge clk); #1;
        if (bus.mem_en && bus.mem_addr == 32'h100 && if_en_n == 0) if_en_n = n;
        if (bus.mem_en && bus.mem_addr == 32'h40 && ma_en_n == 0) ma_en_n = n;
        if (bus.if_ready) begin
          if_rdy_cnt++;
          if (if_rdy_n == 0) if_rdy_n = n;
        end
        if (bus.ma_ready) begin
          ma_rdy_n = n; bus.ma_req = 0;
        end
        if (n == 1) begin
          bus.if_req = 0;
          bus.ma_addr = 32'h40; bus.ma_we = 0; bus.ma_be = 4'hF; bus.ma_req = 1;
        end
      end
      bus.ma_req = 0;
      chk("wd_if_en", if_en_n, 1);
      chk("wd_if_ready_cycle", if_rdy_n, L + 2);
      chk("wd_if_ready_count", if_rdy_cnt, 1);
      chk("wd_if_rdata", bus.if_rdata, 32'h0050_0093);
      chk("wd_ma_en", ma_en_n, L + 4);
      chk("wd_ma_ready_cycle", ma_rdy_n, 2 * L + 5);
      chk("wd_ma_rdata", bus.ma_rdata, 32'hCAFE_BABE);
    end
    begin
      int rdy_cnt;
      rdy_cnt = 0;
      @(posedge clk); #1;
      bus.ma_addr = 32'h40; bus.ma_we = 0; bus.ma_be = 4'hF; bus.ma_req = 1;
      @(posedge clk); #1;
      chk("rw_issue_en", {31'h0, bus.mem_en}, 32'h1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_zero("rw_async");
      bus.ma_req = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (bus.if_ready || bus.ma_ready || bus.mem_en) rdy_cnt++;
      end
      chk("rw_no_activity", rdy_cnt, 0);
      m_if = '0; m_ma = '0;
      run_vec("rw_fresh", v[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
